// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared opcodes and state encoding for the sequential divider
package div_seq_pkg;

   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_ON     = 2'b01,
      DIV_ZERO   = 2'b10,
      DIV_FINISH = 2'b11
   } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract iteration on the {rem,quo} register
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [2*WIDTH-1:0] acc,
   input  logic [WIDTH-1:0]   divisor,
   output logic [2*WIDTH-1:0] acc_next
);

   logic [WIDTH:0] diff;
   logic           fits;

   // The bit shifted out of the top makes the trial remainder exceed any divisor.
   assign diff     = {1'b0, acc[2*WIDTH-2:WIDTH-1]} - {1'b0, divisor};
   assign fits     = acc[2*WIDTH-1] | ~diff[WIDTH];
   assign acc_next = fits ? {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}
                          : {acc[2*WIDTH-2:0], 1'b0};

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle DIV/DIVU sequencer, restoring algorithm, one bit per clock
module div_seq
   import div_seq_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [7:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             annul,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH);

   div_state_t           state, state_next;
   logic [CW-1:0]        count;
   logic [2*WIDTH-1:0]   acc, step_acc;
   logic [WIDTH-1:0]     divisor;
   logic                 neg_q, neg_r;
   logic                 accept, is_signed;
   logic [WIDTH-1:0]     a_mag, b_mag, rem_raw, quo_raw, rem_fix, quo_fix;

   assign is_signed = (op == EXE_DIV_OP);
   assign accept    = start && (is_signed || op == EXE_DIVU_OP);
   assign a_mag     = (is_signed && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (is_signed && b[WIDTH-1]) ? -b : b;

   assign rem_raw   = acc[2*WIDTH-1:WIDTH];
   assign quo_raw   = acc[WIDTH-1:0];
   assign rem_fix   = neg_r ? -rem_raw : rem_raw;
   assign quo_fix   = neg_q ? -quo_raw : quo_raw;

   assign busy      = (state != DIV_IDLE);
   assign done      = (state == DIV_FINISH);

   div_step #(.WIDTH(WIDTH)) u_step (
      .acc      (acc),
      .divisor  (divisor),
      .acc_next (step_acc)
   );

   always_comb begin
      state_next = state;
      case (state)
         DIV_IDLE:   if (accept) state_next = (b == '0) ? DIV_ZERO : DIV_ON;
         DIV_ON: begin
            if (annul)              state_next = DIV_IDLE;
            else if (count == LAST) state_next = DIV_FINISH;
         end
         DIV_ZERO:   state_next = annul ? DIV_IDLE : DIV_ON;
         DIV_FINISH: state_next = DIV_IDLE;
         default:    state_next = DIV_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= DIV_IDLE;
         count   <= '0;
         acc     <= '0;
         divisor <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         state <= state_next;
         case (state)
            DIV_IDLE: begin
               if (accept) begin
                  acc     <= {{WIDTH{1'b0}}, a_mag};
                  divisor <= b_mag;
                  neg_q   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r   <= is_signed && a[WIDTH-1];
                  count   <= '0;
               end
            end
            DIV_ON: begin
               if (!annul) begin
                  // Extra pass at count==LAST applies sign correction on the way into FINISH.
                  if (count == LAST) begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end else begin
                     acc   <= step_acc;
                     count <= count + CW'(1);
                  end
               end
            end
            DIV_ZERO: begin
               acc   <= '0;
               count <= LAST;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq: vector table, corner sequences, random vs model
module tb_div_seq;
   import div_seq_pkg::*;

   logic        clk = 1'b0;
   logic        rst, start, annul;
   logic [7:0]  op;
   logic [31:0] a, b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [7:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cyc;
   } vec_t;

   vec_t tbl[10];

   div_seq #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .op    (op),
      .a     (a),
      .b     (b),
      .annul (annul),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic ref_div(input logic [7:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                          output logic [31:0] rh, output logic [31:0] rl);
      longint          sa, sb, q, r;
      longint unsigned ua, ub, uq, ur;
      if (rb == 0) begin
         rh = 0;
         rl = 0;
      end else if (rop == EXE_DIV_OP) begin
         sa = longint'($signed(ra));
         sb = longint'($signed(rb));
         q  = sa / sb;
         r  = sa % sb;
         rl = q[31:0];
         rh = r[31:0];
      end else begin
         ua = {32'd0, ra};
         ub = {32'd0, rb};
         uq = ua / ub;
         ur = ua % ub;
         rl = uq[31:0];
         rh = ur[31:0];
      end
   endtask

   // Caller is just after an edge; returns edges counted from acceptance until done is seen.
   task automatic wait_done(input int poke, output int cyc);
      bit busy_ok = 1'b1;
      cyc = -1;
      for (int n = 1; n <= 60; n++) begin
         if (n == poke) begin
            start = 1'b1;
            op    = EXE_DIV_OP;
            a     = 32'h7FFF_0000;
            b     = 32'h0000_0003;
         end
         @(posedge clk);
         #1;
         start = 1'b0;
         if (!busy) busy_ok = 1'b0;
         if (done) begin
            cyc = n;
            break;
         end
      end
      check("busy_held", 32'(busy_ok), 32'd1);
   endtask

   task automatic run_div(input string name, input logic [7:0] rop, input logic [31:0] ra,
                          input logic [31:0] rb, input logic [31:0] eh, input logic [31:0] el,
                          input int ecyc, input int poke);
      int cyc;
      start = 1'b1;
      op    = rop;
      a     = ra;
      b     = rb;
      @(posedge clk);
      #1;
      start = 1'b0;
      op    = 8'($urandom);
      a     = $urandom;
      b     = $urandom;
      wait_done(poke, cyc);
      check({name, "_latency"}, 32'(cyc), 32'(ecyc));
      check({name, "_hi"}, hi, eh);
      check({name, "_lo"}, lo, el);
      @(posedge clk);
      #1;
      check({name, "_idle_after"}, {30'd0, busy, done}, 32'd0);
   endtask

   initial begin
      logic [31:0] eh, el;
      logic [7:0]  rop;
      logic [31:0] ra, rb;
      int          cyc, seen;

      tbl[0] = '{EXE_DIVU_OP, 32'd100,        32'd7,          32'd2,          32'd14,         33};
      tbl[1] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  33};
      tbl[2] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'hFFFF_FFFF,  32'd3,          33};
      tbl[3] = '{EXE_DIV_OP,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  33};
      tbl[4] = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'd1,          32'd0,          32'hFFFF_FFFF,  33};
      tbl[5] = '{EXE_DIVU_OP, 32'd5,          32'd0,          32'd0,          32'd0,          2};
      tbl[6] = '{EXE_DIV_OP,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  33};
      tbl[7] = '{EXE_DIVU_OP, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          33};
      tbl[8] = '{EXE_DIVU_OP, 32'hFFFF_FFFF,  32'h8000_0001,  32'h7FFF_FFFE,  32'd1,          33};
      tbl[9] = '{EXE_DIV_OP,  32'hFFFF_FFF9,  32'd0,          32'd0,          32'd0,          2};

      rst = 1'b1; start = 1'b0; annul = 1'b0; op = 8'd0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      for (int i = 0; i < 10; i++)
         run_div($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo,
                 tbl[i].cyc, 0);

      // Non-divide op with start is ignored.
      start = 1'b1; op = 8'h21; a = 32'd9; b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("bad_op_ignored", 32'(busy), 32'd0);

      // Spurious start while busy must not disturb the running operation.
      run_div("start_while_busy", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33, 5);

      // annul in IDLE alongside start: start still taken.
      annul = 1'b1; start = 1'b1; op = EXE_DIVU_OP; a = 32'd9; b = 32'd4;
      @(posedge clk);
      #1;
      annul = 1'b0; start = 1'b0;
      check("annul_idle_busy", 32'(busy), 32'd1);
      wait_done(0, cyc);
      check("annul_idle_latency", 32'(cyc), 32'd33);
      check("annul_idle_lo", lo, 32'd2);
      check("annul_idle_hi", hi, 32'd1);

      // annul in the FINISH cycle has no effect.
      @(posedge clk);
      #1;
      start = 1'b1; op = EXE_DIVU_OP; a = 32'd77; b = 32'd5;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(0, cyc);
      annul = 1'b1;
      check("annul_finish_done", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      annul = 1'b0;
      check("annul_finish_lo", lo, 32'd15);
      check("annul_finish_hi", hi, 32'd2);
      check("annul_finish_idle", 32'(busy), 32'd0);

      // Complete 100/7, then annul 50/3 at iteration 10.
      run_div("pre_annul", EXE_DIVU_OP, 32'd100, 32'd7, 32'd2, 32'd14, 33, 0);
      start = 1'b1; op = EXE_DIVU_OP; a = 32'd50; b = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      annul = 1'b1;
      @(posedge clk);
      #1;
      annul = 1'b0;
      check("annul_busy", 32'(busy), 32'd0);
      check("annul_done", 32'(done), 32'd0);
      check("annul_hi", hi, 32'd2);
      check("annul_lo", lo, 32'd14);
      seen = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (done || busy) seen++;
      end
      check("annul_no_done", 32'(seen), 32'd0);

      // Asynchronous reset mid-iteration.
      start = 1'b1; op = EXE_DIV_OP; a = 32'hFFFF_FF00; b = 32'd7;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_hi", hi, 32'd0);
      check("arst_lo", lo, 32'd0);
      #2;
      rst = 1'b0;

      // Back-to-back random operations against the arithmetic model.
      for (int i = 0; i < 50; i++) begin
         rop = ($urandom_range(0, 1) == 0) ? EXE_DIV_OP : EXE_DIVU_OP;
         ra  = $urandom;
         rb  = $urandom;
         case ($urandom_range(0, 7))
            0: rb = 32'd0;
            1: rb = 32'($urandom_range(1, 15));
            2: ra = 32'h8000_0000;
            3: rb = 32'hFFFF_FFFF;
            default: ;
         endcase
         ref_div(rop, ra, rb, eh, el);
         run_div($sformatf("rnd%0d", i), rop, ra, rb, eh, el, (rb == 0) ? 2 : 33, 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
